// File: rtl/protocol_mep.sv
// Multi-endpoint USB protocol controller: token/data/handshake sequencing with a wait-state watchdog.
// Optional macro DATA_TOGGLE_EN adds per-endpoint data toggles and duplicate-packet detection.
module protocol_mep #(
  parameter int NUM_EP      = 4,
  parameter int BUF_DEPTH   = 64,
  parameter int TIMEOUT_CYC = 255,
  localparam int EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int OCC_W = $clog2(BUF_DEPTH + 1),
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       rx_packet,
  input  logic [3:0]       rx_endpoint,
  input  logic             buffer_reserved,
  input  logic [OCC_W-1:0] tx_packet_data_size,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             tx_busy,
  output logic             d_mode,
  output logic [1:0]       tx_packet,
  output logic             tx_data_pid,
  output logic             clear,
  output logic             tx_error,
  output logic             tx_transfer_active,
  output logic             rx_error,
  output logic             rx_transfer_active,
  output logic             rx_data_ready,
  output logic [EP_W-1:0]  active_ep,
  output logic             timeout
);

  // state        | meaning
  // IDLE         | waiting for OUT/IN token      RX/RX_DATA/RX_DUP | receiving host data
  // RX_ACK       | send ACK                       ACK_WAIT/NCK_WAIT | wait for TX encoder
  // RX_ERR/RX_NCK| receive error, send NAK        BUF_RESERVED      | OUT refused, drain to EOP
  // TX_RESERVED  | NAK refused OUT                TX_NCK            | NAK refused IN
  // TX_DATA      | send DATA                      HOST_WAIT/HOST_NCK| await host handshake / host NAK
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RX        = 4'd1;
  localparam logic [3:0] S_RX_DATA   = 4'd2;
  localparam logic [3:0] S_RX_DUP    = 4'd3;
  localparam logic [3:0] S_RX_ACK    = 4'd4;
  localparam logic [3:0] S_ACK_WAIT  = 4'd5;
  localparam logic [3:0] S_RX_ERR    = 4'd6;
  localparam logic [3:0] S_RX_NCK    = 4'd7;
  localparam logic [3:0] S_NCK_WAIT  = 4'd8;
  localparam logic [3:0] S_BUF_RES   = 4'd9;
  localparam logic [3:0] S_TX_RES    = 4'd10;
  localparam logic [3:0] S_TX_NCK    = 4'd11;
  localparam logic [3:0] S_TX_DATA   = 4'd12;
  localparam logic [3:0] S_HOST_WAIT = 4'd13;
  localparam logic [3:0] S_HOST_NCK  = 4'd14;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_ERR   = 4'b1100;
  localparam logic [3:0] PID_EOP   = 4'b1111;

  localparam logic [4:0]       NUM_EP_V = 5'(NUM_EP);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [3:0]       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             counting, tmr_tc, tmo, dup_q, ep_ok, is_data, tx_pid_sel;

  assign ep_ok    = ({1'b0, rx_endpoint} < NUM_EP_V);
  assign is_data  = (rx_packet == PID_DATA0) || (rx_packet == PID_DATA1);
  assign counting = (state == S_RX) || (state == S_RX_DATA) || (state == S_RX_DUP) ||
                    (state == S_BUF_RES) || (state == S_HOST_WAIT);
  // Down-counter reloads on every state change, so zero means the wait budget is spent.
  assign tmr_tc   = counting && (timer == '0);

`ifdef DATA_TOGGLE_EN
  logic [NUM_EP-1:0] rx_tog, tx_tog;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_tog <= '0;
      tx_tog <= '0;
    end else begin
      if (state == S_RX_DATA && rx_packet == PID_EOP)
        rx_tog[active_ep] <= ~rx_tog[active_ep];
      if (state == S_HOST_WAIT && rx_packet == PID_ACK)
        tx_tog[active_ep] <= ~tx_tog[active_ep];
    end
  end

  assign tx_pid_sel = tx_tog[active_ep];
`else
  assign tx_pid_sel = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_packet == PID_OUT)
          state_nxt = (!ep_ok || buffer_reserved || buffer_occupancy != '0) ? S_BUF_RES : S_RX;
        else if (rx_packet == PID_IN)
          state_nxt = (!ep_ok || buffer_reserved || tx_packet_data_size != buffer_occupancy)
                      ? S_TX_NCK : S_TX_DATA;
      end
      S_RX: begin
        if (is_data) begin
`ifdef DATA_TOGGLE_EN
          state_nxt = (rx_packet[3] == rx_tog[active_ep]) ? S_RX_DATA : S_RX_DUP;
`else
          state_nxt = S_RX_DATA;
`endif
        end else if (rx_packet == PID_ERR) state_nxt = S_RX_ERR;
        else if (tmr_tc) begin state_nxt = S_RX_ERR; tmo = 1'b1; end
      end
      S_RX_DATA: begin
        if (rx_packet == PID_EOP)      state_nxt = S_RX_ACK;
        else if (rx_packet == PID_ERR) state_nxt = S_RX_ERR;
        else if (tmr_tc) begin state_nxt = S_RX_ERR; tmo = 1'b1; end
      end
      S_RX_DUP: begin
        if (rx_packet == PID_EOP) state_nxt = S_RX_ACK;
        else if (tmr_tc) begin state_nxt = S_RX_ERR; tmo = 1'b1; end
      end
      S_RX_ACK:   state_nxt = S_ACK_WAIT;
      S_ACK_WAIT: if (!tx_busy) state_nxt = S_IDLE;
      S_RX_ERR:   state_nxt = S_RX_NCK;
      S_RX_NCK:   state_nxt = S_NCK_WAIT;
      S_NCK_WAIT: if (!tx_busy) state_nxt = S_IDLE;
      S_BUF_RES: begin
        if (rx_packet == PID_EOP) state_nxt = S_TX_RES;
        else if (tmr_tc) begin state_nxt = S_IDLE; tmo = 1'b1; end
      end
      S_TX_RES:   state_nxt = S_NCK_WAIT;
      S_TX_NCK:   state_nxt = S_NCK_WAIT;
      S_TX_DATA:  state_nxt = S_HOST_WAIT;
      S_HOST_WAIT: begin
        if (rx_packet == PID_ACK)      state_nxt = S_IDLE;
        else if (rx_packet == PID_NAK) state_nxt = S_HOST_NCK;
        else if (tmr_tc) begin state_nxt = S_HOST_NCK; tmo = 1'b1; end
      end
      S_HOST_NCK: state_nxt = S_NCK_WAIT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      active_ep <= '0;
      dup_q     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state   <= state_nxt;
      timeout <= tmo;
      dup_q   <= (state == S_RX_DUP);
      if (state_nxt != state) timer <= TMR_LOAD;
      else if (counting)      timer <= timer - 1'b1;
      if (state == S_IDLE && (rx_packet == PID_OUT || rx_packet == PID_IN))
        active_ep <= rx_endpoint[EP_W-1:0];
    end
  end

  always_comb begin
    d_mode             = 1'b0;
    tx_packet          = 2'b11;
    tx_data_pid        = 1'b0;
    clear              = 1'b0;
    tx_error           = 1'b0;
    tx_transfer_active = 1'b0;
    rx_error           = 1'b0;
    rx_transfer_active = 1'b0;
    rx_data_ready      = 1'b0;
    case (state)
      S_IDLE:                       clear = 1'b1;
      S_RX, S_RX_DATA, S_RX_DUP:    rx_transfer_active = 1'b1;
      // dup_q marks an ACK that follows a discarded duplicate.
      S_RX_ACK: begin
        d_mode = 1'b1; tx_packet = 2'b00; rx_data_ready = !dup_q; clear = dup_q;
      end
      S_ACK_WAIT, S_NCK_WAIT:       d_mode = 1'b1;
      S_RX_ERR:                     rx_error = 1'b1;
      S_RX_NCK: begin
        d_mode = 1'b1; tx_packet = 2'b01; rx_error = 1'b1; clear = 1'b1;
      end
      S_BUF_RES:                    d_mode = 1'b0;
      S_TX_RES: begin
        d_mode = 1'b1; tx_packet = 2'b01; rx_error = 1'b1;
      end
      S_TX_NCK: begin
        d_mode = 1'b1; tx_packet = 2'b01; tx_error = 1'b1; clear = 1'b1;
      end
      S_TX_DATA: begin
        d_mode = 1'b1; tx_packet = 2'b10; tx_data_pid = tx_pid_sel; tx_transfer_active = 1'b1;
      end
      S_HOST_WAIT:                  tx_transfer_active = 1'b1;
      S_HOST_NCK: begin
        tx_error = 1'b1; clear = 1'b1;
      end
      default:                      clear = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_protocol_mep.sv
// Self-checking bench for protocol_mep: transaction tasks derive per-cycle expected outputs.
module tb_protocol_mep;
  localparam int NUM_EP = 4;
  localparam int TC     = 20;
  localparam int OCC_W  = 7;

`ifdef DATA_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  localparam logic [3:0] P_NONE = 4'b0000, P_OUT = 4'b0001, P_IN = 4'b1001,
                         P_D0 = 4'b0011, P_D1 = 4'b1011, P_ACK = 4'b0010,
                         P_NAK = 4'b1010, P_ERR = 4'b1100, P_EOP = 4'b1111;

  typedef struct packed {
    logic       d_mode;
    logic [1:0] tx_packet;
    logic       tx_data_pid;
    logic       clear;
    logic       tx_error;
    logic       tx_transfer_active;
    logic       rx_error;
    logic       rx_transfer_active;
    logic       rx_data_ready;
    logic [1:0] active_ep;
    logic       timeout;
  } outs_t;

  logic clk = 1'b0, n_rst = 1'b0;
  logic [3:0] rx_packet = P_NONE, rx_endpoint = 4'd0;
  logic buffer_reserved = 1'b0, tx_busy = 1'b0;
  logic [OCC_W-1:0] tx_packet_data_size = '0, buffer_occupancy = '0;
  logic d_mode, tx_data_pid, clear, tx_error, tx_transfer_active;
  logic rx_error, rx_transfer_active, rx_data_ready, timeout;
  logic [1:0] tx_packet, active_ep;

  protocol_mep #(.NUM_EP(NUM_EP), .BUF_DEPTH(64), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_endpoint(rx_endpoint),
    .buffer_reserved(buffer_reserved), .tx_packet_data_size(tx_packet_data_size),
    .buffer_occupancy(buffer_occupancy), .tx_busy(tx_busy), .d_mode(d_mode),
    .tx_packet(tx_packet), .tx_data_pid(tx_data_pid), .clear(clear), .tx_error(tx_error),
    .tx_transfer_active(tx_transfer_active), .rx_error(rx_error),
    .rx_transfer_active(rx_transfer_active), .rx_data_ready(rx_data_ready),
    .active_ep(active_ep), .timeout(timeout)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {d_mode, tx_packet, tx_data_pid, clear, tx_error, tx_transfer_active,
                rx_error, rx_transfer_active, rx_data_ready, active_ep, timeout};

  int n_checks = 0, n_pass = 0;
  outs_t exp_q[$];
  string nm_q[$];

  // Model of the protocol: endpoint last named by a token and per-endpoint toggles.
  logic [1:0] m_ep = 2'd0;
  bit m_rx_tog [NUM_EP];
  bit m_tx_tog [NUM_EP];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s @%0t: got %b required %b", nm, $time, act, e);
    end
  end

  function automatic outs_t mk(input logic dm, input logic [1:0] tp, input logic pid,
                               input logic clr, input logic te, input logic ta, input logic re,
                               input logic ra, input logic rdy, input logic to);
    outs_t r;
    r = {dm, tp, pid, clr, te, ta, re, ra, rdy, m_ep, to};
    return r;
  endfunction

  function automatic outs_t o_idle(input logic to);   return mk(0, 2'b11, 0, 1, 0, 0, 0, 0, 0, to); endfunction
  function automatic outs_t o_listen();               return mk(0, 2'b11, 0, 0, 0, 0, 0, 1, 0, 0);  endfunction
  function automatic outs_t o_ack(input logic dup);   return mk(1, 2'b00, 0, dup, 0, 0, 0, 0, !dup, 0); endfunction
  function automatic outs_t o_wait();                 return mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);  endfunction
  function automatic outs_t o_rx_err(input logic to); return mk(0, 2'b11, 0, 0, 0, 0, 1, 0, 0, to); endfunction
  function automatic outs_t o_rx_nck();               return mk(1, 2'b01, 0, 1, 0, 0, 1, 0, 0, 0);  endfunction
  function automatic outs_t o_buf_res();              return mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);  endfunction
  function automatic outs_t o_tx_res();               return mk(1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0);  endfunction
  function automatic outs_t o_tx_nck();               return mk(1, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0);  endfunction
  function automatic outs_t o_tx_data(input logic p); return mk(1, 2'b10, p, 0, 0, 1, 0, 0, 0, 0);  endfunction
  function automatic outs_t o_host_wait();            return mk(0, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0);  endfunction
  function automatic outs_t o_host_nck(input logic to); return mk(0, 2'b11, 0, 1, 1, 0, 0, 0, 0, to); endfunction

  task automatic step(input logic [3:0] pid, input logic [3:0] ep, input logic busy,
                      input outs_t e, input string nm);
    @(posedge clk); #1;
    rx_packet = pid; rx_endpoint = ep; tx_busy = busy;
    exp_q.push_back(e); nm_q.push_back(nm);
  endtask

  task automatic peek(output outs_t a);
    @(negedge clk); #1;
    a = act;
  endtask

  task automatic lit(input string nm, input logic [3:0] got, input logic [3:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, req);
  endtask

  task automatic out_txn(input logic [3:0] ep, input logic [3:0] dpid, input int busy_n,
                         output outs_t ack_seen);
    bit dup;
    dup = TOG_EN && (dpid[3] != m_rx_tog[ep]);
    step(P_OUT, ep, 0, o_idle(0), "out_idle");
    m_ep = ep[1:0];
    step(dpid, 4'd0, 0, o_listen(), "out_rx");
    step(P_EOP, 4'd0, 0, o_listen(), dup ? "out_rx_dup" : "out_rx_data");
    step(P_NONE, 4'd0, busy_n > 0, o_ack(dup), "out_ack");
    peek(ack_seen);
    for (int i = 1; i < busy_n; i++) step(P_NONE, 4'd0, 1, o_wait(), "out_ack_wait_busy");
    step(P_NONE, 4'd0, 0, o_wait(), "out_ack_wait");
    if (TOG_EN && !dup) m_rx_tog[ep] = !m_rx_tog[ep];
    step(P_NONE, 4'd0, 0, o_idle(0), "out_done");
  endtask

  // resp: P_ACK, P_NAK, or P_NONE to let the watchdog expire.
  task automatic in_txn(input logic [3:0] ep, input int size, input int occ,
                        input logic [3:0] resp, output outs_t first_seen);
    bit ok;
    tx_packet_data_size = OCC_W'(size);
    buffer_occupancy    = OCC_W'(occ);
    ok = (ep < NUM_EP) && (size == occ);
    step(P_IN, ep, 0, o_idle(0), "in_idle");
    m_ep = ep[1:0];
    if (!ok) begin
      step(P_NONE, 4'd0, 1, o_tx_nck(), "in_tx_nck");
      peek(first_seen);
      step(P_NONE, 4'd0, 0, o_wait(), "in_nck_wait");
    end else begin
      step(P_NONE, 4'd0, 0, o_tx_data(TOG_EN & m_tx_tog[ep]), "in_tx_data");
      peek(first_seen);
      if (resp == P_ACK) begin
        step(P_ACK, 4'd0, 0, o_host_wait(), "in_host_wait");
        if (TOG_EN) m_tx_tog[ep] = !m_tx_tog[ep];
      end else begin
        for (int i = 0; i < ((resp == P_NAK) ? 0 : TC - 1); i++)
          step(P_NONE, 4'd0, 0, o_host_wait(), "in_host_hold");
        step(resp, 4'd0, 0, o_host_wait(), "in_host_last");
        step(P_NONE, 4'd0, 0, o_host_nck(resp != P_NAK), "in_host_nck");
        step(P_NONE, 4'd0, 0, o_wait(), "in_nck_wait");
      end
    end
    tx_packet_data_size = '0;
    buffer_occupancy    = '0;
    step(P_NONE, 4'd0, 0, o_idle(0), "in_done");
  endtask

  // OUT that sits in a wait state for the whole watchdog budget; optionally EOP on the last cycle.
  task automatic rx_wait_txn(input logic [3:0] ep, input logic [3:0] dpid, input bit give_data,
                             input bit eop_on_tc, output outs_t end_seen);
    bit dup;
    dup = give_data && TOG_EN && (dpid[3] != m_rx_tog[ep]);
    step(P_OUT, ep, 0, o_idle(0), "wd_idle");
    m_ep = ep[1:0];
    if (give_data) step(dpid, 4'd0, 0, o_listen(), "wd_rx");
    for (int i = 0; i < TC - 1; i++) step(P_NONE, 4'd0, 0, o_listen(), "wd_hold");
    if (eop_on_tc) begin
      step(P_EOP, 4'd0, 0, o_listen(), "wd_tc_eop");
      step(P_NONE, 4'd0, 0, o_ack(dup), "wd_ack");
      peek(end_seen);
      step(P_NONE, 4'd0, 0, o_wait(), "wd_ack_wait");
      if (TOG_EN && !dup) m_rx_tog[ep] = !m_rx_tog[ep];
    end else begin
      step(P_NONE, 4'd0, 0, o_listen(), "wd_tc");
      step(P_NONE, 4'd0, 0, o_rx_err(1), "wd_rx_err");
      peek(end_seen);
      step(P_NONE, 4'd0, 0, o_rx_nck(), "wd_rx_nck");
      step(P_NONE, 4'd0, 0, o_wait(), "wd_nck_wait");
    end
    step(P_NONE, 4'd0, 0, o_idle(0), "wd_done");
  endtask

  task automatic bufres_txn(input logic [3:0] ep, input int occ, input bit rsv, input bit eop);
    buffer_occupancy = OCC_W'(occ);
    buffer_reserved  = rsv;
    step(P_OUT, ep, 0, o_idle(0), "br_idle");
    m_ep = ep[1:0];
    if (eop) begin
      step(P_EOP, 4'd0, 0, o_buf_res(), "br_res");
      step(P_NONE, 4'd0, 1, o_tx_res(), "br_tx_res");
      step(P_NONE, 4'd0, 0, o_wait(), "br_nck_wait");
      step(P_NONE, 4'd0, 0, o_idle(0), "br_done");
    end else begin
      for (int i = 0; i < TC; i++) step(P_NONE, 4'd0, 0, o_buf_res(), "br_hold");
      step(P_NONE, 4'd0, 0, o_idle(1), "br_timeout_idle");
    end
    buffer_occupancy = '0;
    buffer_reserved  = 1'b0;
  endtask

  initial begin
    outs_t a;
    logic [3:0] dp;

    step(P_NONE, 4'd0, 0, o_idle(0), "reset");
    step(P_NONE, 4'd0, 0, o_idle(0), "reset_hold");
    n_rst = 1'b1;

    out_txn(4'd1, P_D0, 3, a);
    lit("ack_rx_data_ready", {3'b0, a.rx_data_ready}, 4'd1);
    lit("ack_tx_packet", {2'b0, a.tx_packet}, 4'b0000);

    out_txn(4'd1, P_D0, 1, a);
    lit("dup_rx_data_ready", {3'b0, a.rx_data_ready}, {3'b0, !TOG_EN});
    lit("dup_clear", {3'b0, a.clear}, {3'b0, TOG_EN});

    in_txn(4'd2, 8, 8, P_ACK, a);
    lit("in1_tx_packet", {2'b0, a.tx_packet}, 4'b0010);
    lit("in1_pid", {3'b0, a.tx_data_pid}, 4'd0);
    in_txn(4'd2, 8, 8, P_ACK, a);
    lit("in2_pid", {3'b0, a.tx_data_pid}, {3'b0, TOG_EN});

    in_txn(4'd3, 8, 5, P_ACK, a);
    lit("size_nak_tx_error", {3'b0, a.tx_error}, 4'd1);
    lit("size_nak_tx_packet", {2'b0, a.tx_packet}, 4'b0001);

    rx_wait_txn(4'd0, P_D0, 1, 0, a);
    lit("wd_timeout_pulse", {3'b0, a.timeout}, 4'd1);
    lit("wd_rx_error", {3'b0, a.rx_error}, 4'd1);

    rx_wait_txn(4'd2, P_D0, 1, 1, a);
    lit("eop_wins_timeout", {3'b0, a.timeout}, 4'd0);
    lit("eop_wins_ack", {2'b0, a.tx_packet}, 4'b0000);

    rx_wait_txn(4'd3, P_NONE, 0, 0, a);

    in_txn(4'd1, 4, 4, P_NONE, a);
    in_txn(4'd1, 4, 4, P_ACK, a);
    lit("host_timeout_keeps_pid", {3'b0, a.tx_data_pid}, 4'd0);
    in_txn(4'd0, 2, 2, P_NAK, a);

    bufres_txn(4'd4, 0, 0, 1);
    bufres_txn(4'd2, 0, 1, 1);
    bufres_txn(4'd1, 3, 0, 0);

    // Data error during RX_DATA; data PID chosen to match the endpoint's expected toggle.
    dp = m_rx_tog[2] ? P_D1 : P_D0;
    step(P_OUT, 4'd2, 0, o_idle(0), "err_idle");
    m_ep = 2'd2;
    step(dp, 4'd0, 0, o_listen(), "err_rx");
    step(P_ERR, 4'd0, 0, o_listen(), "err_rx_data");
    step(P_NONE, 4'd0, 0, o_rx_err(0), "err_rx_err");
    step(P_NONE, 4'd0, 1, o_rx_nck(), "err_rx_nck");
    step(P_NONE, 4'd0, 0, o_wait(), "err_nck_wait");
    step(P_NONE, 4'd0, 0, o_idle(0), "err_done");

    // Reset while in RX_DATA on ep1.
    dp = m_rx_tog[1] ? P_D1 : P_D0;
    step(P_OUT, 4'd1, 0, o_idle(0), "mid_idle");
    m_ep = 2'd1;
    step(dp, 4'd0, 0, o_listen(), "mid_rx");
    step(P_NONE, 4'd0, 0, o_listen(), "mid_rx_data");
    m_ep = 2'd0;
    for (int i = 0; i < NUM_EP; i++) begin m_rx_tog[i] = 0; m_tx_tog[i] = 0; end
    step(P_NONE, 4'd0, 0, o_idle(0), "mid_reset");
    n_rst = 1'b0;
    step(P_NONE, 4'd0, 0, o_idle(0), "mid_reset_hold");
    n_rst = 1'b1;

    out_txn(4'd1, P_D0, 0, a);
    lit("post_reset_rx_tog", {3'b0, a.rx_data_ready}, 4'd1);
    in_txn(4'd1, 4, 4, P_ACK, a);
    lit("post_reset_tx_tog", {3'b0, a.tx_data_pid}, 4'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/protocol_mep.md
Name: protocol_mep

Overview:
Parametrised multi-endpoint successor of the single-endpoint USB protocol controller FSM. It decodes host token, data and handshake PIDs per endpoint and tracks per-endpoint data toggles. A watchdog timeout keeps the FSM from hanging in any wait state. It sits between the RX packet decoder, the shared data buffer and the TX encoder, and drives the same control outputs with width scaled by the parameters.

Parameters:
NUM_EP, 4, number of endpoints (1..16); EP_W = max(1,$clog2(NUM_EP)) derived
BUF_DEPTH, 64, buffer bytes; OCC_W = $clog2(BUF_DEPTH+1) derived
TIMEOUT_CYC, 255, max cycles in a wait state before abort (>=2); counter width $clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
rx_packet  in  4  decoded PID: 0000 none, 0001 OUT, 1001 IN, 0011 DATA0, 1011 DATA1, 0010 ACK, 1010 NAK, 1100 ERR, 1111 EOP
rx_endpoint  in  4  endpoint number; valid when rx_packet is OUT/IN
buffer_reserved  in  1  buffer owned by TX side
tx_packet_data_size  in  OCC_W  bytes queued for IN
buffer_occupancy  in  OCC_W  current buffer fill
tx_busy  in  1  TX encoder sending
d_mode  out  1  1 = device drives bus
tx_packet  out  2  00 ACK, 01 NAK, 10 DATA, 11 none
tx_data_pid  out  1  toggle for outgoing DATA (0=DATA0, 1=DATA1)
clear  out  1  buffer clear
tx_error, tx_transfer_active, rx_error, rx_transfer_active, rx_data_ready  out  1 each  status
active_ep  out  EP_W  endpoint latched at token
timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Moore decode. Every output is assigned in every state; no latches. Reset forces IDLE: d_mode=0, tx_packet=11, clear=1, all status=0, active_ep=0, toggles=0, timer=0.
- States: IDLE, RX, RX_DATA, RX_DUP, RX_ACK, ACK_WAIT, RX_ERR, RX_NCK, NCK_WAIT, BUF_RESERVED, TX_RESERVED, TX_NCK, TX_DATA, HOST_WAIT, HOST_NCK.
- IDLE + OUT: latch active_ep. Invalid ep (>=NUM_EP), buffer_reserved, or occupancy!=0 -> BUF_RESERVED; else -> RX.
- IDLE + IN: latch active_ep. Invalid ep, buffer_reserved, or size!=occupancy -> TX_NCK; else -> TX_DATA.
- RX + DATAx: PID bit3 == rx_toggle[ep] -> RX_DATA; mismatch -> RX_DUP. RX + ERR -> RX_ERR.
- RX_DATA + EOP -> RX_ACK; flip rx_toggle[ep] on that edge. RX_DATA + ERR -> RX_ERR.
- RX_DUP + EOP -> RX_ACK with rx_data_ready=0 and clear=1 (duplicate discarded, toggle unchanged).
- RX_ACK -> ACK_WAIT: rx_data_ready=1 (non-dup), tx_packet=00, d_mode=1. ACK_WAIT holds while tx_busy, then -> IDLE.
- Error path: RX_ERR -> RX_NCK (rx_error=1, clear=1, tx_packet=01) -> NCK_WAIT (holds on tx_busy) -> IDLE.
- BUF_RESERVED + EOP -> TX_RESERVED (tx_packet=01, rx_error=1) -> NCK_WAIT. TX_NCK (tx_packet=01, tx_error=1, clear=1) -> NCK_WAIT.
- TX_DATA (tx_packet=10, tx_data_pid=tx_toggle[ep], tx_transfer_active=1) -> HOST_WAIT.
- HOST_WAIT + ACK: flip tx_toggle[ep] -> IDLE. HOST_WAIT + NAK -> HOST_NCK (tx_error=1, clear=1) -> NCK_WAIT.
- Watchdog: timer clears on every state change and counts in RX, RX_DATA, RX_DUP, BUF_RESERVED, HOST_WAIT. At count TIMEOUT_CYC-1: pulse timeout. RX/RX_DATA/RX_DUP -> RX_ERR; HOST_WAIT -> HOST_NCK (toggle not flipped); BUF_RESERVED -> IDLE. If a valid PID arrives on the timeout cycle, the PID wins.
- Toggles change only on the named edges. Reset mid-transfer returns to IDLE and zeroes all toggles.

Optional Feature:
DATA_TOGGLE_EN. Defined: per-endpoint toggle registers, RX_DUP path and tx_data_pid tracking as above. Undefined: toggle registers removed, any DATAx goes RX -> RX_DATA, RX_DUP is unreachable, tx_data_pid tied to 0.

Test Plan:
OUT ep1, DATA0, EOP, tx_busy 3 cycles -> RX_ACK: rx_data_ready=1, tx_packet=00; IDLE after busy drops; rx_toggle[1]=1.
Repeat OUT ep1 with DATA0 -> RX_DUP, ACK sent, rx_data_ready=0, clear=1, toggle stays 1.
IN ep2, size=occupancy=8, host ACK -> tx_packet=10, tx_data_pid=0; second IN -> tx_data_pid=1.
IN ep3, size 8 vs occupancy 5 -> TX_NCK: tx_error=1, tx_packet=01; IDLE after tx_busy low.
OUT ep0, DATA0, no EOP for TIMEOUT_CYC cycles -> timeout pulse, RX_ERR -> RX_NCK: rx_error=1.
OUT ep NUM_EP (invalid), EOP -> BUF_RESERVED -> TX_RESERVED: NAK sent; n_rst asserted mid-RX_DATA -> IDLE outputs, toggles 0.
